// File: rtl/frog_pkg.sv
// Shared types for the Frogger key conditioner.
// Key indices, arbitration states and small bit-vector helpers.
package frog_pkg;

    localparam int NUM_KEYS = 4;

    typedef enum logic [1:0] {
        KEY_L,
        KEY_R,
        KEY_U,
        KEY_D
    } key_e;

    typedef enum logic [1:0] {
        IDLE,
        FIRE,
        HOLD
    } kc_state_e;

    function automatic logic [2:0] popcnt(
        input logic [NUM_KEYS-1:0] v
    );
        logic [2:0] c;
        c = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

    // Lowest set bit wins; callers only use it when exactly one bit is set.
    function automatic key_e key_index(
        input logic [NUM_KEYS-1:0] v
    );
        key_e k;
        k = KEY_L;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                k = key_e'(i[1:0]);
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/frog_key_conditioner_debounce.sv
// One raw active-low key: two-flop synchroniser, stability counter,
// debounced level and a one-cycle press event.
module key_debounce
    import frog_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clock,
    input  logic reset,
    input  logic key_n,
    output logic pressed,
    output logic press_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             evt_q, evt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = key_n;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        evt_d    = 1'b0;
        // Any sample agreeing with the stable level restarts the count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                evt_d    = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            evt_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            evt_q    <= evt_d;
            cnt_q    <= cnt_d;
        end
    end

    assign pressed   = ~stable_q;
    assign press_evt = evt_q;

endmodule

// File: rtl/frog_key_conditioner.sv
// Frogger key front end: debounces four buttons and arbitrates them
// into single registered move pulses, rejecting overlapping presses.
module frog_key_conditioner
    import frog_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic [3:0] keys_n,
    output logic       L,
    output logic       R,
    output logic       U,
    output logic       D,
    output logic       busy
);

    logic [NUM_KEYS-1:0] held_vec;
    logic [NUM_KEYS-1:0] evt_vec;
    logic [2:0]          held_cnt;
    logic [2:0]          evt_cnt;

    kc_state_e           state_q, state_d;
    key_e                key_q, key_d;
    logic [NUM_KEYS-1:0] out_q, out_d;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .Clock    (Clock),
            .reset    (reset),
            .key_n    (keys_n[k]),
            .pressed  (held_vec[k]),
            .press_evt(evt_vec[k])
        );
    end

    assign held_cnt = popcnt(held_vec);
    assign evt_cnt  = popcnt(evt_vec);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        out_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (evt_cnt == 3'd1 && held_cnt == 3'd1) begin
                    state_d = FIRE;
                    key_d   = key_index(evt_vec);
                end else if (evt_cnt != 3'd0) begin
                    state_d = HOLD;
                end
            end
            FIRE: state_d = HOLD;
            HOLD: begin
                if (held_cnt == 3'd0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Pulse register loads alongside the FIRE state so it lasts one cycle.
        if (state_d == FIRE) begin
            out_d = NUM_KEYS'(1) << key_d;
        end
    end

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= KEY_L;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            out_q   <= out_d;
        end
    end

    assign L    = out_q[KEY_L];
    assign R    = out_q[KEY_R];
    assign U    = out_q[KEY_U];
    assign D    = out_q[KEY_D];
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_frog_key_conditioner.sv
// Scoreboard bench for frog_key_conditioner with DEBOUNCE_CYCLES=4.
// Expected pulses are queued with their cycle; a monitor pops on every pulse.
module tb_frog_key_conditioner;

    logic       Clock;
    logic       reset;
    logic [3:0] keys_n;
    logic       L, R, U, D, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [3:0] pulse;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    frog_key_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .Clock (Clock),
        .reset (reset),
        .keys_n(keys_n),
        .L     (L),
        .R     (R),
        .U     (U),
        .D     (D),
        .busy  (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge Clock) begin
        logic [3:0] got;
        exp_t e;
        got = {D, U, R, L};
        if (got != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d got=%b required=none",
                         cyc, got);
            end else begin
                e = sb.pop_front();
                if (e.pulse != got || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL pulse got=%b@%0d required=%b@%0d",
                             got, cyc, e.pulse, e.cyc);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    // Caller sits just after posedge k; the key is first sampled at k+1.
    task automatic expect_pulse(input logic [3:0] p);
        exp_t e;
        e.pulse = p;
        e.cyc   = cyc + 7;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        step(12);
        chk(name, sb.size(), 0);
    endtask

    task automatic chk_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            chk(name, int'({L, R, U, D, busy}), 0);
        end
        step(0);
    endtask

    task automatic release_busy(input string name);
        keys_n = 4'b1111;
        step(6);
        @(negedge Clock);
        chk({name, "_busy_hi"}, int'(busy), 1);
        step(1);
        @(negedge Clock);
        chk({name, "_busy_lo"}, int'(busy), 0);
        step(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b0;
        keys_n = 4'b1011;
        chk_quiet("reset_quiet", 8);
        @(posedge Clock);
        #1;
        reset = 1'b1;
        expect_pulse(4'b0100);
        step(15);
        keys_n = 4'b1111;
        drain("reset_release_u");

        // Clean U press held 50 cycles.
        keys_n = 4'b1011;
        expect_pulse(4'b0100);
        step(50);
        release_busy("clean_u");
        drain("clean_u");

        // Bounce on L: 0,1,0 then held.
        keys_n = 4'b1110;
        step(1);
        keys_n = 4'b1111;
        step(1);
        keys_n = 4'b1110;
        expect_pulse(4'b0001);
        step(20);
        release_busy("bounce_l");
        drain("bounce_l");

        // L and R pressed on the same edge.
        keys_n = 4'b1100;
        step(20);
        @(negedge Clock);
        chk("simul_busy", int'(busy), 1);
        step(0);
        keys_n = 4'b1101;
        step(15);
        @(negedge Clock);
        chk("simul_one_left_busy", int'(busy), 1);
        step(0);
        release_busy("simul");
        drain("simul");
        keys_n = 4'b1011;
        expect_pulse(4'b0100);
        step(15);
        release_busy("after_simul_u");
        drain("after_simul_u");

        // R fires, then D pressed while R held.
        keys_n = 4'b1101;
        expect_pulse(4'b0010);
        step(12);
        keys_n = 4'b0101;
        step(20);
        release_busy("overlap");
        drain("overlap");
        keys_n = 4'b0111;
        expect_pulse(4'b1000);
        step(15);
        release_busy("after_overlap_d");
        drain("after_overlap_d");

        // Reset two cycles into a U debounce.
        keys_n = 4'b1011;
        step(2);
        reset = 1'b0;
        chk_quiet("mid_reset_quiet", 6);
        @(posedge Clock);
        #1;
        reset = 1'b1;
        expect_pulse(4'b0100);
        step(15);
        release_busy("mid_reset_u");
        drain("mid_reset_u");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
